prbs_checker: RTL and testbench

- Receive-side checker for the PRBS-15 serial stream (x^15 + x^14 + 1) produced by the PRBS generator stage. Sits directly downstream and consumes its serial bit output.
- Self-synchronising: predicts each bit from the previous 15 received bits, independent of generator seed.
- Runs a hunt/sync/lock state machine and reports lock status plus saturating error and bit counts.

---
 rtl/prbs_pkg.sv | 19 +
 rtl/prbs_checker_sat_counter.sv | 23 ++
 rtl/prbs_checker.sv | 164 ++++++++++++++++
 tb/tb_prbs_checker.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-15 receive checker: FSM encoding, polynomial
// taps and the default order/seed used by the generator stage and benches.
package prbs_pkg;

  // Checker FSM encoding; value 3 is unused and recovers to FILL.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // x^15 + x^14 + 1: the next bit is history[14] ^ history[13].
  localparam int TAP_A = 14;
  localparam int TAP_B = 13;

  localparam int          DEFAULT_TYPE = 15;
  localparam logic [14:0] GEN_SEED     = 15'h2ABC;

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int Width = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  output logic [Width-1:0] count
);

  // Count up on enable, hold at all-ones, clear on request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {Width{1'b1}})) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-15 checker. Predicts each received bit from the
// previous 15, hunts for a clean run to declare lock, and tracks errors in a
// sliding-free fixed window to decide when lock is lost.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int Type       = DEFAULT_TYPE,
  parameter int LockThresh = 32,
  parameter int LossThresh = 8,
  parameter int LossWindow = 64,
  parameter int CntWidth   = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BitIn,
  input  logic                BitValid,
  input  logic                ClrCnt,
  output logic                Locked,
  output logic                ErrPulse,
  output logic [CntWidth-1:0] ErrCount,
  output logic [CntWidth-1:0] BitCount,
  output logic [1:0]          State
);

  localparam int FillW   = $clog2(Type + 1);
  localparam int MatchW  = $clog2(LockThresh + 1);
  localparam int WinCntW = $clog2(LossWindow + 1);
  localparam int WinErrW = $clog2(LossThresh + 1);

  state_t               state_reg, state_next;
  logic [Type-1:0]      hist_reg, hist_next;
  logic [FillW-1:0]     fill_cnt_reg, fill_cnt_next;
  logic [MatchW-1:0]    match_cnt_reg, match_cnt_next;
  logic [WinCntW-1:0]   win_cnt_reg, win_cnt_next;
  logic [WinErrW-1:0]   win_err_reg, win_err_next;
  logic [WinErrW-1:0]   win_err_sum;
  logic                 err_pulse_reg, err_pulse_next;
  logic                 mismatch;
  logic                 cnt_en [2];
  logic [CntWidth-1:0]  cnt_val [2];

  // Prediction from the two oldest taps; only meaningful on a valid bit.
  assign mismatch = BitValid && (BitIn != (hist_reg[TAP_A] ^ hist_reg[TAP_B]));

  // Next-state, history and window bookkeeping for the hunt/sync/lock FSM.
  always_comb begin
    state_next     = state_reg;
    hist_next      = hist_reg;
    fill_cnt_next  = fill_cnt_reg;
    match_cnt_next = match_cnt_reg;
    win_cnt_next   = win_cnt_reg;
    win_err_next   = win_err_reg;
    win_err_sum    = win_err_reg + WinErrW'(mismatch);
    err_pulse_next = 1'b0;
    cnt_en[0]      = 1'b0;
    cnt_en[1]      = 1'b0;

    if (BitValid) begin
      hist_next = {hist_reg[Type-2:0], BitIn};
    end

    case (state_reg)
      FILL: begin
        if (BitValid) begin
          if (fill_cnt_reg == FillW'(Type - 1)) begin
            state_next     = SYNC;
            fill_cnt_next  = '0;
            match_cnt_next = '0;
          end else begin
            fill_cnt_next = fill_cnt_reg + FillW'(1);
          end
        end
      end

      SYNC: begin
        if (BitValid) begin
          if (mismatch) begin
            match_cnt_next = '0;
          end else if (match_cnt_reg == MatchW'(LockThresh - 1)) begin
            state_next     = LOCKED;
            match_cnt_next = '0;
            win_cnt_next   = '0;
            win_err_next   = '0;
          end else begin
            match_cnt_next = match_cnt_reg + MatchW'(1);
          end
        end
      end

      LOCKED: begin
        if (BitValid) begin
          cnt_en[1] = 1'b1;
          if (mismatch) begin
            err_pulse_next = 1'b1;
            cnt_en[0]      = 1'b1;
          end
          // Threshold is tested with the current bit included, before any
          // window-end clear, so a boundary error still counts.
          if (win_err_sum == WinErrW'(LossThresh)) begin
            state_next     = SYNC;
            match_cnt_next = '0;
            win_cnt_next   = '0;
            win_err_next   = '0;
          end else if (win_cnt_reg == WinCntW'(LossWindow - 1)) begin
            win_cnt_next = '0;
            win_err_next = '0;
          end else begin
            win_cnt_next = win_cnt_reg + WinCntW'(1);
            win_err_next = win_err_sum;
          end
        end
      end

      default: begin
        state_next    = FILL;
        fill_cnt_next = '0;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= FILL;
      hist_reg      <= '0;
      fill_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      win_cnt_reg   <= '0;
      win_err_reg   <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hist_reg      <= hist_next;
      fill_cnt_reg  <= fill_cnt_next;
      match_cnt_reg <= match_cnt_next;
      win_cnt_reg   <= win_cnt_next;
      win_err_reg   <= win_err_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

  // Index 0 counts mismatches, index 1 counts checked bits, both while locked.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(
        .Width(CntWidth)
      ) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (cnt_en[gi]),
        .clr   (ClrCnt),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign ErrCount = cnt_val[0];
  assign BitCount = cnt_val[1];
  assign ErrPulse = err_pulse_reg;
  assign Locked   = (state_reg == LOCKED);
  assign State    = state_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a default-parameter instance for lock,
// error and reset behaviour, and a narrow-counter instance for saturation.
module tb_prbs_checker;
  import prbs_pkg::*;

  logic        CLK;
  logic        RST;
  logic        BitIn, BitValid, ClrCnt;
  logic        Locked, ErrPulse;
  logic [15:0] ErrCount, BitCount;
  logic [1:0]  State;

  logic        bit_s, valid_s, clr_s;
  logic        locked_s, pulse_s;
  logic [3:0]  errcnt_s, bitcnt_s;
  logic [1:0]  state_s;

  logic [14:0] gen;
  int          checks;
  int          errors;

  prbs_checker dut (
    .CLK      (CLK),
    .RST      (RST),
    .BitIn    (BitIn),
    .BitValid (BitValid),
    .ClrCnt   (ClrCnt),
    .Locked   (Locked),
    .ErrPulse (ErrPulse),
    .ErrCount (ErrCount),
    .BitCount (BitCount),
    .State    (State)
  );

  prbs_checker #(
    .LossThresh (65),
    .CntWidth   (4)
  ) dut_sat (
    .CLK      (CLK),
    .RST      (RST),
    .BitIn    (bit_s),
    .BitValid (valid_s),
    .ClrCnt   (clr_s),
    .Locked   (locked_s),
    .ErrPulse (pulse_s),
    .ErrCount (errcnt_s),
    .BitCount (bitcnt_s),
    .State    (state_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference PRBS-15 generator: new bit = s[14]^s[13], shifted in at bit 0.
  task automatic gen_bit(output logic b);
    b   = gen[14] ^ gen[13];
    gen = {gen[13:0], b};
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    @(negedge CLK);
    BitIn = b; BitValid = v; ClrCnt = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic step_sat(input logic b, input logic v, input logic c);
    @(negedge CLK);
    bit_s = b; valid_s = v; clr_s = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0;
    BitValid = 1'b0; ClrCnt = 1'b0;
    valid_s = 1'b0; clr_s = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    @(negedge CLK);
    obs = {Locked, ErrPulse, ErrCount, BitCount, State};
    checks++;
    if (obs !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    @(negedge CLK);
    RST = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (State !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle_state: State=%0d expected 0", State);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_lock();
    logic b;
    apply_reset();
    gen = GEN_SEED;
    for (int i = 1; i <= 46; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
    end
    checks++;
    if (Locked !== 1'b0 || State !== 2'd1) begin
      errors++;
      $display("FAIL clean_before_lock: Locked=%0b State=%0d expected 0/1", Locked, State);
    end
    gen_bit(b);
    step(b, 1'b1, 1'b0);
    checks++;
    if (Locked !== 1'b1 || State !== 2'd2) begin
      errors++;
      $display("FAIL clean_lock_rise: Locked=%0b State=%0d expected 1/2", Locked, State);
    end
    for (int i = 0; i < 200; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
    end
    checks++;
    if (BitCount !== 16'd200 || ErrCount !== 16'd0) begin
      errors++;
      $display("FAIL clean_counts: BitCount=%0d ErrCount=%0d expected 200/0", BitCount, ErrCount);
    end
    $display("test_clean_lock: BitCount=%0d ErrCount=%0d", BitCount, ErrCount);
  endtask

  task automatic test_gapped();
    logic       b;
    logic [1:0] st;
    logic [15:0] bc;
    int         idle_changes;
    logic       locked46;
    idle_changes = 0;
    locked46 = 1'b0;
    apply_reset();
    gen = GEN_SEED;
    for (int i = 1; i <= 57; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      if (i == 46) locked46 = Locked;
      if (i == 47) begin
        checks++;
        if (Locked !== 1'b1) begin
          errors++;
          $display("FAIL gapped_lock_rise: Locked=%0b expected 1", Locked);
        end
      end
      st = State;
      bc = BitCount;
      step(~b, 1'b0, 1'b0);
      if (State !== st || BitCount !== bc) idle_changes++;
    end
    checks++;
    if (locked46 !== 1'b0) begin
      errors++;
      $display("FAIL gapped_early_lock: Locked=%0b after 46 bits expected 0", locked46);
    end
    checks++;
    if (idle_changes !== 0) begin
      errors++;
      $display("FAIL gapped_idle: %0d idle cycles changed state expected 0", idle_changes);
    end
    checks++;
    if (BitCount !== 16'd10 || ErrCount !== 16'd0) begin
      errors++;
      $display("FAIL gapped_counts: BitCount=%0d ErrCount=%0d expected 10/0", BitCount, ErrCount);
    end
    $display("test_gapped: BitCount=%0d idle_changes=%0d", BitCount, idle_changes);
  endtask

  task automatic test_single_error();
    logic        b;
    logic [19:0] pulses;
    pulses = '0;
    for (int k = 0; k < 20; k++) begin
      gen_bit(b);
      if (k == 0) b = ~b;
      step(b, 1'b1, 1'b0);
      pulses[k] = ErrPulse;
    end
    checks++;
    if (pulses !== 20'h0C001) begin
      errors++;
      $display("FAIL single_err_pulses: got %h expected 0c001", pulses);
    end
    checks++;
    if (ErrCount !== 16'd3 || Locked !== 1'b1) begin
      errors++;
      $display("FAIL single_err_count: ErrCount=%0d Locked=%0b expected 3/1", ErrCount, Locked);
    end
    $display("test_single_error: pulses=%h ErrCount=%0d", pulses, ErrCount);
  endtask

  task automatic test_loss_of_lock();
    logic        b;
    logic [199:0] lk;
    logic [15:0] err_at_loss;
    err_at_loss = '0;
    apply_reset();
    gen = GEN_SEED;
    for (int i = 1; i <= 47; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
    end
    for (int k = 0; k < 200; k++) begin
      gen_bit(b);
      if ((k % 20) == 0 && k < 160) b = ~b;
      step(b, 1'b1, 1'b0);
      lk[k] = Locked;
      if (k == 54) err_at_loss = ErrCount;
    end
    checks++;
    if (lk[53] !== 1'b1 || lk[54] !== 1'b0) begin
      errors++;
      $display("FAIL loss_fall: Locked[53]=%0b Locked[54]=%0b expected 1/0", lk[53], lk[54]);
    end
    checks++;
    if (err_at_loss !== 16'd8) begin
      errors++;
      $display("FAIL loss_errcount: ErrCount=%0d expected 8", err_at_loss);
    end
    checks++;
    if (lk[186] !== 1'b0 || lk[187] !== 1'b1 || lk[199] !== 1'b1) begin
      errors++;
      $display("FAIL relock: Locked[186]=%0b [187]=%0b [199]=%0b expected 0/1/1",
               lk[186], lk[187], lk[199]);
    end
    $display("test_loss_of_lock: ErrCount=%0d Locked=%0b", ErrCount, Locked);
  endtask

  task automatic test_counter_sat();
    logic b;
    apply_reset();
    gen = GEN_SEED;
    for (int i = 1; i <= 47; i++) begin
      gen_bit(b);
      step_sat(b, 1'b1, 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      gen_bit(b);
      step_sat(~b, 1'b1, 1'b0);
    end
    checks++;
    if (errcnt_s !== 4'd15 || bitcnt_s !== 4'd15 || locked_s !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: ErrCount=%0d BitCount=%0d Locked=%0b expected 15/15/1",
               errcnt_s, bitcnt_s, locked_s);
    end
    gen_bit(b);
    step_sat(~b, 1'b1, 1'b1);
    checks++;
    if (errcnt_s !== 4'd0 || bitcnt_s !== 4'd0 || pulse_s !== 1'b1) begin
      errors++;
      $display("FAIL clr_collision: ErrCount=%0d BitCount=%0d ErrPulse=%0b expected 0/0/1",
               errcnt_s, bitcnt_s, pulse_s);
    end
    gen_bit(b);
    step_sat(~b, 1'b1, 1'b0);
    checks++;
    if (errcnt_s !== 4'd1 || bitcnt_s !== 4'd1 || locked_s !== 1'b1) begin
      errors++;
      $display("FAIL after_clr: ErrCount=%0d BitCount=%0d Locked=%0b expected 1/1/1",
               errcnt_s, bitcnt_s, locked_s);
    end
    valid_s = 1'b0;
    $display("test_counter_sat: ErrCount=%0d BitCount=%0d", errcnt_s, bitcnt_s);
  endtask

  task automatic test_reset_midrun();
    logic        b;
    logic [36:0] obs;
    checks++;
    if (Locked !== 1'b1) begin
      errors++;
      $display("FAIL midrun_precondition: Locked=%0b expected 1", Locked);
    end
    @(negedge CLK);
    BitValid = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    obs = {Locked, ErrPulse, ErrCount, BitCount, State};
    checks++;
    if (obs !== 37'd0) begin
      errors++;
      $display("FAIL midrun_async_reset: got %h expected 0", obs);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 1; i <= 46; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
    end
    checks++;
    if (Locked !== 1'b0) begin
      errors++;
      $display("FAIL midrun_early_lock: Locked=%0b expected 0", Locked);
    end
    gen_bit(b);
    step(b, 1'b1, 1'b0);
    checks++;
    if (Locked !== 1'b1) begin
      errors++;
      $display("FAIL midrun_relock: Locked=%0b expected 1", Locked);
    end
    $display("test_reset_midrun: Locked=%0b", Locked);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b0;
    BitIn = 1'b0; BitValid = 1'b0; ClrCnt = 1'b0;
    bit_s = 1'b0; valid_s = 1'b0; clr_s = 1'b0;
    gen = GEN_SEED;
    test_reset();
    test_clean_lock();
    test_gapped();
    test_single_error();
    test_loss_of_lock();
    test_reset_midrun();
    test_counter_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
